// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash transaction sequencer.
// Sequencer phases, byte-port states and common flash opcodes.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_HOLD,
        ST_FIN
    } xfer_state_t;

    typedef enum logic [1:0] {
        PT_IDLE,
        PT_WAIT,
        PT_GAP
    } port_state_t;

    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_PP      = 8'h02;
    localparam logic [7:0] OP_WREN    = 8'h06;
    localparam logic [7:0] OP_RDSR    = 8'h05;
    localparam logic [7:0] OP_RDID    = 8'h9F;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;

endpackage

// File: rtl/spi_byte_port.sv
// Single-byte req/ack handshake with the byte-level SPI master.
// A byte is accepted only from PT_IDLE; PT_GAP keeps wr_req low long enough for the master to settle.
module spi_byte_port
    import spi_flash_pkg::*;
(
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] tx,
    output logic       idle,
    output logic       done,
    output logic [7:0] rx,
    output logic       wr_req,
    output logic [7:0] data_in,
    input  logic       wr_ack,
    input  logic [7:0] data_out
);

    port_state_t st, st_nx;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) st <= PT_IDLE;
        else     st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            PT_IDLE: if (load)   st_nx = PT_WAIT;
            PT_WAIT: if (wr_ack) st_nx = PT_GAP;
            default:             st_nx = PT_IDLE;
        endcase
    end

    assign idle   = (st == PT_IDLE);
    assign wr_req = (st == PT_WAIT);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            data_in <= 8'h00;
            rx      <= 8'h00;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (st == PT_IDLE && load) data_in <= tx;
            if (st == PT_WAIT && wr_ack) begin
                rx   <= data_out;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_flash_xfer_ctrl.sv
// Turns one flash command request into a complete nCS-framed SPI transaction.
// Sequences opcode/address/dummy/data phases; byte-level handshaking lives in spi_byte_port.
module spi_flash_xfer_ctrl
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W   = 24,
    parameter int LEN_W    = 9,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              cmd_req,
    output logic              cmd_ack,
    input  logic [7:0]        cmd_code,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_has_addr,
    input  logic [3:0]        cmd_dummy,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_dir,
    input  logic [7:0]        wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [7:0]        rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic              done,
    output logic              spi_nCS_ctrl,
    output logic              spi_wr_req,
    output logic [7:0]        spi_data_in,
    input  logic              spi_wr_ack,
    input  logic [7:0]        spi_data_out
);

    xfer_state_t       state, state_nx;
    logic [7:0]        code_q;
    logic [ADDR_W-1:0] addr_sr;
    logic              has_addr_q;
    logic [3:0]        dummy_q;
    logic [LEN_W-1:0]  len_q, cnt;
    logic              dir_q;
    logic [7:0]        tcnt;
    logic              load, port_idle, port_done;
    logic [7:0]        tx;

    // First non-empty phase following 'from'; empty phases cost no byte slots.
    function automatic xfer_state_t next_phase(input xfer_state_t from);
        if (from == ST_CMD && has_addr_q)              return ST_ADDR;
        if (from != ST_DUMMY && dummy_q != 4'd0)       return ST_DUMMY;
        if (len_q != '0)                               return ST_DATA;
        return ST_HOLD;
    endfunction

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // The last phase byte's done arrives one cycle after its ack, so HOLD needs CS_HOLD-1 more cycles.
    always_comb begin
        state_nx    = state;
        load        = 1'b0;
        tx          = DUMMY_BYTE;
        wdata_ready = 1'b0;
        case (state)
            ST_IDLE:  if (cmd_req) state_nx = ST_SETUP;
            ST_SETUP: if (tcnt == 8'(CS_SETUP - 1)) begin
                load     = 1'b1;
                tx       = code_q;
                state_nx = ST_CMD;
            end
            ST_CMD:   if (port_done) state_nx = next_phase(ST_CMD);
            ST_ADDR: begin
                tx   = addr_sr[ADDR_W-1 -: 8];
                load = port_idle;
                if (port_done && cnt == LEN_W'(1)) state_nx = next_phase(ST_ADDR);
            end
            ST_DUMMY: begin
                load = port_idle;
                if (port_done && cnt == LEN_W'(1)) state_nx = next_phase(ST_DUMMY);
            end
            ST_DATA: begin
                if (dir_q) begin
                    tx          = wdata;
                    load        = port_idle && wdata_valid;
                    wdata_ready = load;
                end else begin
                    load = port_idle;
                end
                if (port_done && cnt == LEN_W'(1)) state_nx = ST_HOLD;
            end
            ST_HOLD:  if (tcnt == 8'(CS_HOLD - 2)) state_nx = ST_FIN;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cmd_ack    <= 1'b0;
            tcnt       <= 8'd0;
            code_q     <= 8'h00;
            addr_sr    <= '0;
            has_addr_q <= 1'b0;
            dummy_q    <= 4'd0;
            len_q      <= '0;
            dir_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            cmd_ack <= (state == ST_IDLE) && cmd_req;
            tcnt    <= (state_nx != state) ? 8'd0 : tcnt + 8'd1;
            if (state == ST_IDLE && cmd_req) begin
                code_q     <= cmd_code;
                addr_sr    <= cmd_addr;
                has_addr_q <= cmd_has_addr;
                dummy_q    <= cmd_dummy;
                len_q      <= cmd_len;
                dir_q      <= cmd_dir;
            end
            if (state_nx != state) begin
                case (state_nx)
                    ST_ADDR:  cnt <= LEN_W'(ADDR_W / 8);
                    ST_DUMMY: cnt <= LEN_W'(dummy_q);
                    ST_DATA:  cnt <= len_q;
                    default:  ;
                endcase
            end else if (port_done) begin
                cnt <= cnt - LEN_W'(1);
            end
            if (state == ST_ADDR && port_done) addr_sr <= addr_sr << 8;
        end
    end

    assign busy         = (state != ST_IDLE) && (state != ST_FIN);
    assign done         = (state == ST_FIN);
    assign spi_nCS_ctrl = (state == ST_IDLE) || (state == ST_FIN);
    assign rdata_valid  = port_done && (state == ST_DATA) && !dir_q;

    spi_byte_port u_port (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .load     (load),
        .tx       (tx),
        .idle     (port_idle),
        .done     (port_done),
        .rx       (rdata),
        .wr_req   (spi_wr_req),
        .data_in  (spi_data_in),
        .wr_ack   (spi_wr_ack),
        .data_out (spi_data_out)
    );

endmodule

// File: tb/tb_spi_flash_xfer_ctrl.sv
// Randomised scoreboard bench: behavioural byte-level SPI master + flash responder,
// expected MOSI bytes and read data queued at issue time and popped by monitors.
module tb_spi_flash_xfer_ctrl;
    import spi_flash_pkg::*;

    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_req = 1'b0, cmd_ack;
    logic [7:0]  cmd_code = 8'h00;
    logic [23:0] cmd_addr = 24'h0;
    logic        cmd_has_addr = 1'b0;
    logic [3:0]  cmd_dummy = 4'd0;
    logic [8:0]  cmd_len = 9'd0;
    logic        cmd_dir = 1'b0;
    logic [7:0]  wdata;
    logic        wdata_valid, wdata_ready;
    logic [7:0]  rdata;
    logic        rdata_valid, busy, done;
    logic        spi_nCS_ctrl, spi_wr_req;
    logic [7:0]  spi_data_in;
    logic        spi_wr_ack;
    logic [7:0]  spi_data_out;

    always #5 sys_clk = ~sys_clk;

    spi_flash_xfer_ctrl #(.ADDR_W(24), .LEN_W(9), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
        .sys_clk(sys_clk), .rst(rst), .cmd_req(cmd_req), .cmd_ack(cmd_ack),
        .cmd_code(cmd_code), .cmd_addr(cmd_addr), .cmd_has_addr(cmd_has_addr),
        .cmd_dummy(cmd_dummy), .cmd_len(cmd_len), .cmd_dir(cmd_dir),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done),
        .spi_nCS_ctrl(spi_nCS_ctrl), .spi_wr_req(spi_wr_req), .spi_data_in(spi_data_in),
        .spi_wr_ack(spi_wr_ack), .spi_data_out(spi_data_out)
    );

    int n_cmp = 0, n_err = 0;
    logic [7:0] q_mosi[$], q_rd[$], q_wr[$];
    bit  cur_ha = 0, aborted = 0, hold_wr = 0;
    int  cur_dummy = 0, frame_exp_bytes = 0, cyc = 0;
    int  n_done = 0, n_ack = 0, exp_ack = 0, n_ready = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
        #2;
    endtask

    function automatic logic [7:0] mem(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    // Flash reply for data byte i of a frame with opcode op at address a.
    function automatic logic [7:0] resp(input logic [7:0] op, input logic [23:0] a, input int i);
        if (op == OP_RDID) begin
            case (i % 3)
                0:       return 8'hEF;
                1:       return 8'h40;
                default: return 8'h18;
            endcase
        end
        if (op == OP_RDSR) return 8'h02 ^ 8'(i);
        return mem(a + 24'(i));
    endfunction

    // Byte-level SPI master + flash responder.
    initial begin
        int lat = 0, c_ack = -10, k = 0, low = 0, low_ack = 0, hdr = 0;
        bit inb = 0, prev_cs = 1, chk_drop = 0;
        logic [23:0] fa = 0;
        logic [7:0]  fop = 0, held = 0;
        spi_wr_ack = 1'b0;
        spi_data_out = 8'h00;
        forever begin
            @(negedge sys_clk);
            cyc++;
            spi_wr_ack = 1'b0;
            if (rst) begin
                inb = 0; prev_cs = 1; chk_drop = 0; k = 0; low = 0;
                continue;
            end
            if (chk_drop) begin
                chk("wr_req drop after ack", 32'(spi_wr_req), 0);
                chk_drop = 0;
            end
            if (!spi_nCS_ctrl) begin
                if (prev_cs) begin k = 0; low = 0; low_ack = 0; fa = 0; end
                low++;
            end else if (!prev_cs && !aborted) begin
                chk("cs hold cycles", 32'(low - low_ack), CS_HOLD);
                chk("frame byte count", 32'(k), 32'(frame_exp_bytes));
            end
            prev_cs = spi_nCS_ctrl;
            if (spi_wr_req && !inb) begin
                inb = 1;
                held = spi_data_in;
                lat = $urandom_range(0, 3);
                chk("wr_req spacing", 32'(cyc - c_ack >= 2), 1);
                chk("wr_req nCS low", 32'(spi_nCS_ctrl), 0);
                if (k == 0) chk("cs setup cycles", 32'(low - 1), CS_SETUP);
            end
            if (inb) begin
                chk("data_in stable", 32'(spi_data_in), 32'(held));
                if (lat == 0) begin
                    spi_wr_ack = 1'b1;
                    if (q_mosi.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL mosi byte: got %0h expected none", held);
                    end else begin
                        chk("mosi byte", 32'(held), 32'(q_mosi.pop_front()));
                    end
                    if (k == 0) fop = held;
                    else if (cur_ha && k <= 3) fa = {fa[15:0], held};
                    hdr = 1 + (cur_ha ? 3 : 0) + cur_dummy;
                    spi_data_out = (k >= hdr) ? resp(fop, fa, k - hdr) : 8'hFF;
                    k++;
                    inb = 0;
                    c_ack = cyc;
                    low_ack = low;
                    chk_drop = 1;
                end else begin
                    lat--;
                end
            end else if (!spi_wr_req && $urandom_range(0, 7) == 0) begin
                spi_wr_ack = 1'b1;   // stray ack, must be ignored
                spi_data_out = 8'h77;
            end
        end
    end

    // Write-data source with random gaps.
    initial begin
        bit took = 0;
        int gap = 0;
        wdata_valid = 1'b0;
        wdata = 8'h00;
        forever begin
            @(negedge sys_clk);
            if (took) begin
                void'(q_wr.pop_front());
                n_ready++;
                gap = $urandom_range(0, 3);
            end else if (gap > 0) begin
                gap--;
            end
            if (!hold_wr && gap == 0 && q_wr.size() > 0) begin
                wdata_valid = 1'b1;
                wdata = q_wr[0];
            end else begin
                wdata_valid = 1'b0;
                wdata = 8'($urandom);
            end
            #1 took = wdata_valid && wdata_ready;
        end
    end

    // Output monitor.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!rst) begin
                if (cmd_ack) n_ack++;
                if (done) begin
                    n_done++;
                    chk("nCS high at done", 32'(spi_nCS_ctrl), 1);
                    chk("busy low at done", 32'(busy), 0);
                end
                if (rdata_valid) begin
                    if (q_rd.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL rdata: got %0h expected none", rdata);
                    end else begin
                        chk("rdata", 32'(rdata), 32'(q_rd.pop_front()));
                    end
                end
            end
        end
    end

    task automatic prep(input logic [7:0] op, input logic [23:0] a, input bit ha,
                        input int dm, input int len, input bit dir, input bit fixed);
        logic [7:0] b;
        cur_ha = ha;
        cur_dummy = dm;
        aborted = 0;
        q_mosi.push_back(op);
        if (ha) for (int i = 2; i >= 0; i--) q_mosi.push_back(a[i*8 +: 8]);
        for (int i = 0; i < dm; i++) q_mosi.push_back(DUMMY_BYTE);
        for (int i = 0; i < len; i++) begin
            if (dir) begin
                b = fixed ? ((i % 2 == 0) ? 8'hA5 : 8'h5A) : 8'($urandom);
                q_wr.push_back(b);
                q_mosi.push_back(b);
            end else begin
                q_mosi.push_back(8'h00);
                q_rd.push_back(resp(op, a, i));
            end
        end
        frame_exp_bytes = 1 + (ha ? 3 : 0) + dm + len;
        cmd_code = op; cmd_addr = a; cmd_has_addr = ha;
        cmd_dummy = 4'(dm); cmd_len = 9'(len); cmd_dir = dir;
    endtask

    task automatic issue();
        cmd_req = 1'b1;
        step();
        cmd_req = 1'b0;
        chk("cmd_ack pulse", 32'(cmd_ack), 1);
        chk("busy after ack", 32'(busy), 1);
        exp_ack++;
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [23:0] a, input bit ha,
                           input int dm, input int len, input bit dir, input bit stall);
        int d0, r0, t;
        bit ok;
        step();
        prep(op, a, ha, dm, len, dir, stall);
        d0 = n_done;
        r0 = n_ready;
        hold_wr = stall;
        issue();
        if (!stall && $urandom_range(0, 1) == 1) begin
            step();
            cmd_req = 1'b1;
            cmd_code = 8'hAB;
            repeat (3) step();
            cmd_req = 1'b0;
        end
        if (stall) begin
            t = 0;
            while (q_mosi.size() > len && t < 500) begin step(); t++; end
            chk("header bytes before stall", 32'(t < 500), 1);
            ok = 1;
            repeat (20) begin
                step();
                ok &= !spi_wr_req && !spi_nCS_ctrl && !wdata_ready && busy;
            end
            chk("write stall holds nCS low, no wr_req", 32'(ok), 1);
            hold_wr = 0;
        end
        t = 0;
        while (n_done == d0 && t < 6000) begin step(); t++; end
        repeat (3) step();
        chk("single done", 32'(n_done - d0), 1);
        chk("wdata_ready count", 32'(n_ready - r0), dir ? 32'(len) : 0);
        chk("mosi queue drained", 32'(q_mosi.size()), 0);
        chk("rdata queue drained", 32'(q_rd.size()), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op;
        int d0, t;
        repeat (3) @(negedge sys_clk);
        chk("reset nCS", 32'(spi_nCS_ctrl), 1);
        chk("reset wr_req", 32'(spi_wr_req), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset cmd_ack", 32'(cmd_ack), 0);
        chk("reset rdata_valid", 32'(rdata_valid), 0);
        chk("reset data_in", 32'(spi_data_in), 0);
        #2 rst = 1'b0;
        repeat (3) step();
        chk("idle nCS", 32'(spi_nCS_ctrl), 1);

        run_cmd(OP_WREN, 24'h0, 0, 0, 0, 0, 0);
        run_cmd(OP_RDID, 24'h0, 0, 0, 3, 0, 0);
        run_cmd(OP_READ, 24'h123456, 1, 0, 4, 0, 0);
        run_cmd(OP_PP, 24'h000100, 1, 0, 2, 1, 1);
        run_cmd(8'h0B, 24'h000000, 1, 1, 1, 0, 0);
        run_cmd(OP_READ, 24'hFFFF80, 1, 0, 256, 0, 0);
        run_cmd(8'h20, 24'h0A0000, 1, 0, 0, 0, 0);

        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 6))
                0: run_cmd(OP_READ, 24'($urandom), 1, 0, $urandom_range(1, 8), 0, 0);
                1: run_cmd(8'h0B, 24'($urandom), 1, $urandom_range(1, 3), $urandom_range(1, 6), 0, 0);
                2: run_cmd(OP_RDID, 24'h0, 0, 0, $urandom_range(1, 3), 0, 0);
                3: run_cmd(OP_RDSR, 24'h0, 0, 0, $urandom_range(1, 4), 0, 0);
                4: run_cmd(OP_PP, 24'($urandom), 1, 0, $urandom_range(1, 8), 1, 0);
                5: run_cmd(OP_WREN, 24'h0, 0, 0, 0, 0, 0);
                default: begin
                    op = 8'h20;
                    run_cmd(op, 24'($urandom), 1, 0, 0, 0, 0);
                end
            endcase
        end

        // Reset in the middle of the second address byte.
        step();
        prep(OP_READ, 24'h123456, 1, 0, 4, 0, 0);
        issue();
        t = 0;
        while (!(q_mosi.size() == frame_exp_bytes - 2 && spi_wr_req) && t < 500) begin step(); t++; end
        chk("reached addr byte 2", 32'(t < 500), 1);
        d0 = n_done;
        aborted = 1;
        rst = 1'b1;
        #1;
        chk("abort nCS high", 32'(spi_nCS_ctrl), 1);
        chk("abort wr_req low", 32'(spi_wr_req), 0);
        chk("abort busy low", 32'(busy), 0);
        q_mosi.delete();
        q_rd.delete();
        repeat (4) step();
        rst = 1'b0;
        repeat (6) step();
        chk("no done after abort", 32'(n_done - d0), 0);
        run_cmd(OP_WREN, 24'h0, 0, 0, 0, 0, 0);

        chk("cmd_ack total", 32'(n_ack), 32'(exp_ack));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
